// File: rtl/cache_arbiter.sv
// cache_arbiter: arbitrates icache/dcache line requests onto a beat-wide memory bus,
// one transaction in flight, alternating priority on ties.
module cache_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           i_addr,
  input  logic                  i_read,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic [31:0]           d_addr,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic [31:0]           bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [31:0]           bmem_raddr,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_rvalid
);
  localparam int BURST = LINE_WIDTH / BEAT_WIDTH;
  localparam logic [1:0] LAST = 2'(BURST - 1);
  typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_DATA, RESP} state_e;
  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic last_grant_q, last_grant_d, gnt_q, gnt_d;
  logic [31:0] addr_q, addr_d;
  logic [BURST-1:0][BEAT_WIDTH-1:0] line_q, line_d, wbeats;
  logic d_pend, pick_d, unused_raddr;
  assign wbeats = d_wdata;
  assign d_pend = d_read | d_write;
  // grant/last_grant: 1 = dcache; a tie goes to whoever was not granted last
  assign pick_d = d_pend & (~i_read | ~last_grant_q);
  assign unused_raddr = ^bmem_raddr;
  assign bmem_addr = addr_q;
  assign bmem_read = state_q == RD_CMD;
  assign bmem_write = state_q == WR_DATA;
  assign bmem_wdata = bmem_write ? wbeats[cnt_q] : '0;
  assign i_rdata = line_q;
  assign d_rdata = line_q;
  assign i_resp = (state_q == RESP) & ~gnt_q;
  assign d_resp = (state_q == RESP) & gnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_grant_q <= 1'b0;
      gnt_q <= 1'b0;
      addr_q <= '0;
      line_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_grant_q <= last_grant_d;
      gnt_q <= gnt_d;
      addr_q <= addr_d;
      line_q <= line_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_grant_d = last_grant_q;
    gnt_d = gnt_q;
    addr_d = addr_q;
    line_d = line_q;
    case (state_q)
      IDLE: if (i_read | d_pend) begin
        gnt_d = pick_d;
        last_grant_d = pick_d;
        addr_d = (pick_d ? d_addr : i_addr) & ~32'h1f;
        cnt_d = '0;
        state_d = (pick_d & d_write) ? WR_DATA : RD_CMD;
      end
      RD_CMD: if (bmem_ready) begin
        cnt_d = '0;
        state_d = RD_DATA;
      end
      RD_DATA: if (bmem_rvalid) begin
        line_d[cnt_q] = bmem_rdata;
        cnt_d = cnt_q + 2'd1;
        state_d = cnt_q == LAST ? RESP : RD_DATA;
      end
      WR_DATA: if (bmem_ready) begin
        cnt_d = cnt_q + 2'd1;
        state_d = cnt_q == LAST ? RESP : WR_DATA;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed and randomized transactions against a bench-side memory
// responder and a transaction-level expectation model.
module tb_cache_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] i_addr, d_addr, bmem_addr, bmem_raddr;
  logic i_read, d_read, d_write, i_resp, d_resp;
  logic bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic [255:0] i_rdata, d_rdata, d_wdata;
  logic [63:0] bmem_wdata, bmem_rdata;
  int n_cmp = 0, n_bad = 0;
  bit last_d = 1'b0, stray = 1'b0;
  int stall_at = -1, stall_n = 0, lat;
  logic [63:0] beats [4];
  logic [63:0] wseq [$];
  logic [3:0][63:0] wv;
  int idx [6] = '{0, 1, 1, 1, 2, 3};

  cache_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] r256();
    logic [255:0] v = '0;
    for (int k = 0; k < 8; k++) v = {v[223:0], 32'($urandom)};
    return v;
  endfunction

  // Plays memory and requester for one transaction starting in an IDLE cycle.
  task automatic run_txn(input bit exp_d, input int rdy_pct, input int rv_pct, output int l);
    logic [31:0] ea;
    logic [63:0] wq [$];
    bit wr, got = 1'b0, addr_ok = 1'b1, both = 1'b0, armed = 1'b0;
    int sent = 0, rd_acc = 0, last_acc = -100, stalls = 0;
    wr = exp_d && d_write;
    ea = (exp_d ? d_addr : i_addr) & 32'hffff_ffe0;
    last_d = exp_d;
    for (int k = 0; k < 4; k++) beats[k] = {$urandom, $urandom};
    wseq.delete();
    l = 0;
    for (int c = 1; c <= 300 && !got; c++) begin
      if (i_resp || d_resp) begin
        got = 1'b1;
        l = c;
      end else begin
        if (bmem_read && bmem_write) both = 1'b1;
        if ((bmem_read || bmem_write) && bmem_addr !== ea) addr_ok = 1'b0;
        bmem_ready = ($urandom_range(99) < rdy_pct);
        if (bmem_write && wq.size() == stall_at && stalls < stall_n) begin
          bmem_ready = 1'b0;
          stalls++;
        end
        if (bmem_write) wseq.push_back(bmem_wdata);
        if (bmem_write && bmem_ready) begin
          wq.push_back(bmem_wdata);
          last_acc = c;
        end
        bmem_rvalid = 1'b0;
        bmem_rdata = {$urandom, $urandom};
        if (armed && sent < 4) begin
          if ($urandom_range(99) < rv_pct) begin
            bmem_rvalid = 1'b1;
            bmem_rdata = beats[2'(sent)];
            sent++;
          end
        end else if (stray && $urandom_range(1) == 1) bmem_rvalid = 1'b1;
        if (bmem_read && bmem_ready) begin
          rd_acc++;
          armed = 1'b1;
        end
        tick;
      end
    end
    chk("resp_seen", got, 1);
    if (got) begin
      chk("resp_target", {i_resp, d_resp}, exp_d ? 2'b01 : 2'b10);
      chk("bus_idle_in_resp", {bmem_read, bmem_write}, 2'b00);
      if (wr) begin
        wv = d_wdata;
        chk("wr_accepted", wq.size(), 4);
        for (int k = 0; k < wq.size() && k < 4; k++) chk("wr_beat", wq[k], wv[2'(k)]);
        chk("wr_no_read", rd_acc, 0);
        chk("wr_resp_timing", l, last_acc + 1);
      end else begin
        chk("rd_cmds", rd_acc, 1);
        chk("rd_line", exp_d ? d_rdata : i_rdata, {beats[3], beats[2], beats[1], beats[0]});
      end
      chk("addr_aligned", addr_ok, 1);
      chk("no_rd_wr_overlap", both, 0);
    end
    if (exp_d) {d_read, d_write} = 2'b00;
    else i_read = 1'b0;
    bmem_ready = 1'b0;
    bmem_rvalid = 1'b0;
    tick;
    chk("resp_one_cycle", {i_resp, d_resp}, 2'b00);
  endtask

  initial begin
    {i_read, d_read, d_write, bmem_ready, bmem_rvalid} = '0;
    i_addr = '0; d_addr = '0; d_wdata = '0; bmem_rdata = '0; bmem_raddr = '0;
    tick;
    tick;
    chk("rst_bus", {bmem_read, bmem_write, bmem_addr, bmem_wdata}, '0);
    chk("rst_resp", {i_resp, d_resp}, 2'b00);
    chk("rst_i_rdata", i_rdata, '0);
    chk("rst_d_rdata", d_rdata, '0);
    rst_n = 1'b1;
    tick;
    // Known-address full-speed read
    i_addr = 32'h1eceb004;
    i_read = 1'b1;
    begin : directed_read
      logic [63:0] q [$];
      int c = 0, rd_cyc = 0, sent = 0;
      bit got = 1'b0;
      bmem_ready = 1'b1;
      while (!got && c < 50) begin
        c++;
        if (i_resp) got = 1'b1;
        else begin
          if (bmem_read) begin
            rd_cyc++;
            chk("req27_addr", bmem_addr, 32'h1eceb000);
          end
          bmem_rvalid = 1'b0;
          if (rd_cyc > 0 && !bmem_read && sent < 4) begin
            bmem_rvalid = 1'b1;
            bmem_rdata = {8{8'(8'h11 * (sent + 1))}};
            sent++;
          end
          tick;
        end
      end
      chk("req27_latency", c, 7);
      chk("req27_read_cycles", rd_cyc, 1);
      chk("req27_line", i_rdata, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});
      i_read = 1'b0;
      bmem_rvalid = 1'b0;
      bmem_ready = 1'b0;
      tick;
      chk("req27_pulse", i_resp, 0);
    end
    last_d = 1'b0;
    // Ties alternate, icache granted immediately after the dcache response
    i_addr = $urandom; d_addr = $urandom; i_read = 1'b1; d_read = 1'b1;
    run_txn(1, 100, 100, lat);
    chk("tie1_latency", lat, 7);
    run_txn(0, 100, 100, lat);
    chk("after_d_latency", lat, 7);
    i_addr = $urandom; d_addr = $urandom; i_read = 1'b1; d_read = 1'b1;
    run_txn(1, 100, 100, lat);
    run_txn(0, 100, 100, lat);
    // Write with a two-cycle stall on beat 1
    d_addr = $urandom; d_wdata = r256(); d_write = 1'b1;
    stall_at = 1; stall_n = 2;
    run_txn(1, 100, 100, lat);
    stall_at = -1; stall_n = 0;
    wv = d_wdata;
    chk("req29_seq_len", wseq.size(), 6);
    for (int k = 0; k < 6 && k < wseq.size(); k++) chk("req29_seq", wseq[k], wv[2'(idx[k])]);
    // Read+write together is a write
    d_addr = $urandom; d_wdata = r256(); d_write = 1'b1; d_read = 1'b1;
    run_txn(1, 70, 100, lat);
    // Stray rvalid in IDLE and during a write
    for (int k = 0; k < 2; k++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata = {$urandom, $urandom};
      tick;
      chk("stray_idle_no_resp", {i_resp, d_resp}, 2'b00);
    end
    bmem_rvalid = 1'b0;
    stray = 1'b1;
    d_addr = $urandom; d_wdata = r256(); d_write = 1'b1;
    run_txn(1, 80, 100, lat);
    i_addr = $urandom; i_read = 1'b1;
    run_txn(0, 100, 100, lat);
    // Randomized mix
    for (int t = 0; t < 24; t++) begin
      if (!i_read && $urandom_range(1) == 1) begin
        i_addr = $urandom;
        i_read = 1'b1;
      end
      if (!(d_read || d_write) && $urandom_range(1) == 1) begin
        d_addr = $urandom;
        d_wdata = r256();
        d_write = 1'($urandom_range(1));
        d_read = !d_write || ($urandom_range(1) == 1);
      end
      if (!i_read && !(d_read || d_write)) begin
        i_addr = $urandom;
        i_read = 1'b1;
      end
      stray = 1'($urandom_range(1));
      run_txn((d_read || d_write) && (!i_read || !last_d), $urandom_range(50, 100), $urandom_range(40, 100), lat);
    end
    while (i_read || d_read || d_write)
      run_txn((d_read || d_write) && (!i_read || !last_d), 100, 100, lat);
    stray = 1'b0;
    // Reset in the middle of a read burst
    i_addr = $urandom; i_read = 1'b1; bmem_ready = 1'b1;
    tick;
    tick;
    bmem_rvalid = 1'b1;
    bmem_rdata = 64'hdead_beef_0000_0001;
    tick;
    bmem_rdata = 64'hdead_beef_0000_0002;
    tick;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_bus", {bmem_read, bmem_write, bmem_addr}, '0);
    chk("rst_mid_rdata", i_rdata, '0);
    chk("rst_mid_resp", {i_resp, d_resp}, 2'b00);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("rst_hold_no_resp", {i_resp, d_resp}, 2'b00);
    end
    i_read = 1'b0; bmem_rvalid = 1'b0; bmem_ready = 1'b0;
    rst_n = 1'b1;
    last_d = 1'b0;
    tick;
    i_addr = $urandom; d_addr = $urandom; i_read = 1'b1; d_read = 1'b1;
    run_txn(1, 100, 100, lat);
    run_txn(0, 100, 100, lat);
    chk("post_rst_latency", lat, 7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
